// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared definitions for the MEM-stage load/store unit:
//                RV32I funct3 encodings, the LSU state enum and small
//                decode helpers for validity, alignment and byte lane.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // Load encodings
  localparam logic [2:0] c_f3_lb  = 3'b000;
  localparam logic [2:0] c_f3_lh  = 3'b001;
  localparam logic [2:0] c_f3_lw  = 3'b010;
  localparam logic [2:0] c_f3_lbu = 3'b100;
  localparam logic [2:0] c_f3_lhu = 3'b101;
  // Store encodings
  localparam logic [2:0] c_f3_sb  = 3'b000;
  localparam logic [2:0] c_f3_sh  = 3'b001;
  localparam logic [2:0] c_f3_sw  = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LD_DATA   = 2'd1,
    S_LD_RSP    = 2'd2,
    S_RMW_MERGE = 2'd3
  } lsu_state_t;

  // funct3 legality depends on direction: stores only have SB/SH/SW.
  function automatic logic f3_valid(input logic we, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (we) begin
      ok = (f3 == c_f3_sb) || (f3 == c_f3_sh) || (f3 == c_f3_sw);
    end else begin
      ok = (f3 == c_f3_lb) || (f3 == c_f3_lh) || (f3 == c_f3_lw) ||
           (f3 == c_f3_lbu) || (f3 == c_f3_lhu);
    end
    return ok;
  endfunction

  // funct3[1:0] encodes the access size for both loads and stores.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    case (f3[1:0])
      2'b01:   mis = lo[0];
      2'b10:   mis = |lo;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Byte lane with the low bits forced to natural alignment.
  function automatic logic [1:0] align_lane(input logic [2:0] f3, input logic [1:0] lo);
    logic [1:0] lane;
    lane = lo;
    case (f3[1:0])
      2'b00:   lane = lo;
      2'b01:   lane = {lo[1], 1'b0};
      default: lane = 2'b00;
    endcase
    return lane;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_byte_lane.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_byte_lane
//  Description : Combinational lane logic. Extracts and sign/zero-extends a
//                load result from a memory word, and merges store data into
//                a memory word for read-modify-write.
//  Ports       : i_lane    - byte lane (already aligned to access size)
//                i_funct3  - RV32I funct3 (size in [1:0], unsigned in [2])
//                i_rdata   - word read from memory
//                i_wdata   - right-aligned store data
//                o_load    - extended load result
//                o_merge   - i_rdata with the addressed lane(s) replaced
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [4:0]  w_shift;
  logic [31:0] w_field;
  logic [31:0] w_mask;

  assign w_shift = {i_lane, 3'b000};
  assign w_field = i_rdata >> w_shift;

  always_comb begin
    o_load = i_rdata;
    case (i_funct3)
      c_f3_lb:  o_load = {{24{w_field[7]}}, w_field[7:0]};
      c_f3_lh:  o_load = {{16{w_field[15]}}, w_field[15:0]};
      c_f3_lbu: o_load = {24'h000000, w_field[7:0]};
      c_f3_lhu: o_load = {16'h0000, w_field[15:0]};
      default:  o_load = i_rdata;
    endcase
  end

  always_comb begin
    w_mask = 32'hFFFF_FFFF;
    case (i_funct3[1:0])
      2'b00:   w_mask = 32'h0000_00FF << w_shift;
      2'b01:   w_mask = 32'h0000_FFFF << w_shift;
      default: w_mask = 32'hFFFF_FFFF;
    endcase
  end

  assign o_merge = (i_rdata & ~w_mask) | ((i_wdata << w_shift) & w_mask);

endmodule
`default_nettype wire

// File: rtl/lsu_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_mem_stage
//  Description : RV32I MEM-stage load/store unit in front of a word-addressed
//                data memory with a registered read port. Loads take two
//                cycles to respond, SW writes in the accept cycle, SB/SH use
//                a two-cycle read-modify-write.
//  Config      : LSU_MISALIGN_TRAP_EN - when defined, misaligned halfword and
//                word accesses are rejected with req_fault; otherwise the low
//                address bits are masked to natural alignment.
//  Ports       : clk, rst (sync, active-high)
//                req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata
//                resp_valid/resp_rdata - load response (one-cycle pulse)
//                req_fault             - rejected request (one-cycle pulse)
//                mem_r_enable/mem_w_enable/mem_address/mem_wr_data/mem_re_data
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int DMEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        req_fault,
  output logic        mem_r_enable,
  output logic        mem_w_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_re_data
);

  localparam int c_idx_w = $clog2(DMEM_WORDS);

  lsu_state_t r_state;
  lsu_state_t w_next;

  logic [2:0]         r_f3;
  logic [1:0]         r_lane;
  logic [c_idx_w-1:0] r_index;
  logic [31:0]        r_wdata;
  logic               r_fault;
  logic [31:0]        r_rdata;

  logic               w_accept;
  logic               w_bad;
  logic               w_go;
  logic [c_idx_w-1:0] w_index;
  logic [31:0]        w_load;
  logic [31:0]        w_merge;
  logic               w_unused_addr;

  // Dropping the upper address bits is what makes the index wrap.
  assign w_index       = req_addr[c_idx_w+1:2];
  assign w_unused_addr = &{1'b0, req_addr[31:c_idx_w+2]};

  assign req_ready = ~rst & ((r_state == S_IDLE) | (r_state == S_LD_RSP));
  assign w_accept  = req_valid & req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_bad = ~f3_valid(req_we, req_funct3) | misaligned(req_funct3, req_addr[1:0]);
`else
  assign w_bad = ~f3_valid(req_we, req_funct3);
`endif

  assign w_go = w_accept & ~w_bad;

  // One instance serves both the load extract (LD_DATA) and the store
  // merge (RMW_MERGE); both work from the latched request fields.
  lsu_byte_lane u_lane (
    .i_lane   (r_lane),
    .i_funct3 (r_f3),
    .i_rdata  (mem_re_data),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merge  (w_merge)
  );

  always_comb begin
    w_next       = r_state;
    mem_r_enable = 1'b0;
    mem_w_enable = 1'b0;
    mem_address  = {{(32-c_idx_w){1'b0}}, w_index};
    mem_wr_data  = req_wdata;
    case (r_state)
      S_IDLE, S_LD_RSP: begin
        w_next = S_IDLE;
        if (w_go) begin
          if (!req_we) begin
            mem_r_enable = 1'b1;
            w_next       = S_LD_DATA;
          end else if (req_funct3 == c_f3_sw) begin
            mem_w_enable = 1'b1;
          end else begin
            mem_r_enable = 1'b1;
            w_next       = S_RMW_MERGE;
          end
        end
      end
      S_LD_DATA: begin
        mem_address = {{(32-c_idx_w){1'b0}}, r_index};
        w_next      = S_LD_RSP;
      end
      S_RMW_MERGE: begin
        mem_w_enable = 1'b1;
        mem_address  = {{(32-c_idx_w){1'b0}}, r_index};
        mem_wr_data  = w_merge;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Reset must block the pending RMW write so the word stays intact.
    if (rst) begin
      mem_r_enable = 1'b0;
      mem_w_enable = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_f3    <= 3'b000;
      r_lane  <= 2'b00;
      r_index <= '0;
      r_wdata <= 32'h0;
      r_fault <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      r_state <= w_next;
      r_fault <= w_accept & w_bad;
      if (w_go) begin
        r_f3    <= req_funct3;
        r_lane  <= align_lane(req_funct3, req_addr[1:0]);
        r_index <= w_index;
        r_wdata <= req_wdata;
      end
      if (r_state == S_LD_DATA) begin
        r_rdata <= w_load;
      end
    end
  end

  assign resp_valid = ~rst & (r_state == S_LD_RSP);
  assign resp_rdata = r_rdata;
  assign req_fault  = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_mem_stage
//  Description : Self-checking bench for lsu_mem_stage. A registered-read
//                data memory sits behind the DUT; expected load values come
//                from a byte-level reference memory updated with plain
//                arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_stage;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        req_fault;
  logic        mem_r_enable;
  logic        mem_w_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_re_data;

  int checks   = 0;
  int failures = 0;

  logic [31:0] dmem    [32];
  logic [31:0] ref_mem [32];

  lsu_mem_stage #(.DMEM_WORDS(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .req_fault    (req_fault),
    .mem_r_enable (mem_r_enable),
    .mem_w_enable (mem_w_enable),
    .mem_address  (mem_address),
    .mem_wr_data  (mem_wr_data),
    .mem_re_data  (mem_re_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: registered read, synchronous write.
  always @(posedge clk) begin
    if (mem_w_enable) dmem[mem_address[4:0]] <= mem_wr_data;
    if (mem_r_enable) mem_re_data <= dmem[mem_address[4:0]];
  end

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit ref_legal(input logic we, input logic [2:0] f3);
    if (we) return f3 <= 3'd2;
    return (f3 != 3'd3) && (f3 <= 3'd5);
  endfunction

  function automatic bit ref_trap(input logic [2:0] f3, input logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
    return (addr % acc_size(f3)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
    int          sz;
    int          a;
    logic [63:0] m;
    logic [63:0] v;
    sz = acc_size(f3);
    a  = int'(addr % 256) - int'(addr % 256) % sz;
    m  = (64'd1 << (8 * sz)) - 64'd1;
    v  = ({32'h0, ref_mem[(a / 4) % 32]} >> (8 * (a % 4))) & m;
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~m;
    return v[31:0];
  endfunction

  function automatic void ref_store(input logic [2:0] f3, input logic [31:0] addr,
                                    input logic [31:0] wd);
    int          sz;
    int          a;
    logic [63:0] m;
    logic [63:0] w;
    sz = acc_size(f3);
    a  = int'(addr % 256) - int'(addr % 256) % sz;
    m  = ((64'd1 << (8 * sz)) - 64'd1) << (8 * (a % 4));
    w  = {32'h0, ref_mem[(a / 4) % 32]};
    w  = (w & ~m) | (({32'h0, wd} << (8 * (a % 4))) & m);
    ref_mem[(a / 4) % 32] = w[31:0];
  endfunction

  // ---------------- transaction driver ----------------
  // Presents one request, waits for acceptance, then watches three cycles.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] rdata,
                      output int resp_cyc, output bit fault, output bit acc_ren,
                      output bit acc_wen, output logic [31:0] acc_addr,
                      output bit wen1);
    int n;
    n = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    #1;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 10) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: req_ready=%0b after %0d cycles, required 1", req_ready, n);
    end
    acc_ren  = mem_r_enable;
    acc_wen  = mem_w_enable;
    acc_addr = mem_address;
    @(posedge clk);
    #1 req_valid = 1'b0;
    resp_cyc = 0;
    fault    = 1'b0;
    wen1     = 1'b0;
    rdata    = 32'h0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (resp_valid && resp_cyc == 0) begin
        resp_cyc = k;
        rdata    = resp_rdata;
      end
      if (req_fault) fault = 1'b1;
      if (k == 1 && mem_w_enable) wen1 = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst        = 1'b1;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, mem_r_enable, mem_w_enable, resp_valid, req_fault} !== 5'b0 ||
        resp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: ready=%0b ren=%0b wen=%0b rv=%0b fault=%0b rdata=%h, required all 0",
               req_ready, mem_r_enable, mem_w_enable, resp_valid, req_fault, resp_rdata);
    end
    req_valid = 1'b0;
    #1 rst = 1'b0;
  endtask

  task automatic test_lw_basic();
    logic [31:0] rd, aa;
    int          rc;
    bit          f, ar, aw, w1;
    xact(1'b0, 3'b010, 32'h14, 32'h0, rd, rc, f, ar, aw, aa, w1);
    checks++;
    if (ar !== 1'b1 || aw !== 1'b0 || aa !== 32'd5) begin
      failures++;
      $display("FAIL lw_accept: ren=%0b wen=%0b addr=%0d, required ren=1 wen=0 addr=5", ar, aw, aa);
    end
    checks++;
    if (rc !== 2 || rd !== 32'h5 || f !== 1'b0) begin
      failures++;
      $display("FAIL lw_resp: cycle=%0d data=%h fault=%0b, required cycle=2 data=00000005 fault=0", rc, rd, f);
    end
  endtask

  task automatic test_subword();
    logic [31:0] rd, aa;
    int          rc;
    bit          f, ar, aw, w1;
    logic [31:0] exp_v [6];
    logic [2:0]  ld_f3 [6];
    logic [31:0] ld_a  [6];
    exp_v = '{32'h00008002, 32'hFFFFFF80, 32'h00000080, 32'hBEEF0003, 32'hFFFFBEEF, 32'h0000BEEF};
    ld_f3 = '{3'b010, 3'b000, 3'b100, 3'b010, 3'b001, 3'b101};
    ld_a  = '{32'h08, 32'h09, 32'h09, 32'h0C, 32'h0E, 32'h0E};
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        xact(1'b1, 3'b000, 32'h09, 32'h80, rd, rc, f, ar, aw, aa, w1);
        ref_store(3'b000, 32'h09, 32'h80);
        checks++;
        if (ar !== 1'b1 || aw !== 1'b0 || w1 !== 1'b1 || rc !== 0 || f !== 1'b0) begin
          failures++;
          $display("FAIL sb_rmw: ren=%0b wen=%0b wen_t1=%0b resp=%0d fault=%0b, required 1 0 1 0 0",
                   ar, aw, w1, rc, f);
        end
      end
      if (i == 3) begin
        xact(1'b1, 3'b001, 32'h0E, 32'hBEEF, rd, rc, f, ar, aw, aa, w1);
        ref_store(3'b001, 32'h0E, 32'hBEEF);
      end
      xact(1'b0, ld_f3[i], ld_a[i], 32'h0, rd, rc, f, ar, aw, aa, w1);
      checks++;
      if (rc !== 2 || rd !== exp_v[i]) begin
        failures++;
        $display("FAIL subword_load%0d: cycle=%0d data=%h, required cycle=2 data=%h",
                 i, rc, rd, exp_v[i]);
      end
    end
  endtask

  task automatic test_misalign();
    logic [31:0] rd, aa;
    int          rc;
    bit          f, ar, aw, w1;
    xact(1'b0, 3'b010, 32'h06, 32'h0, rd, rc, f, ar, aw, aa, w1);
    checks++;
`ifdef LSU_MISALIGN_TRAP_EN
    if (f !== 1'b1 || ar !== 1'b0 || aw !== 1'b0 || rc !== 0) begin
      failures++;
      $display("FAIL misalign_trap: fault=%0b ren=%0b wen=%0b resp=%0d, required 1 0 0 0", f, ar, aw, rc);
    end
`else
    if (f !== 1'b0 || rc !== 2 || rd !== 32'h1) begin
      failures++;
      $display("FAIL misalign_mask: fault=%0b resp=%0d data=%h, required 0 2 00000001", f, rc, rd);
    end
`endif
  endtask

  task automatic test_invalid_f3();
    logic [31:0] rd, aa;
    int          rc;
    bit          f, ar, aw, w1;
    xact(1'b0, 3'b011, 32'h00, 32'h0, rd, rc, f, ar, aw, aa, w1);
    checks++;
    if (f !== 1'b1 || ar !== 1'b0 || rc !== 0) begin
      failures++;
      $display("FAIL bad_load_f3: fault=%0b ren=%0b resp=%0d, required 1 0 0", f, ar, rc);
    end
    xact(1'b1, 3'b100, 32'h00, 32'hDEAD, rd, rc, f, ar, aw, aa, w1);
    checks++;
    if (f !== 1'b1 || ar !== 1'b0 || aw !== 1'b0 || w1 !== 1'b0) begin
      failures++;
      $display("FAIL bad_store_f3: fault=%0b ren=%0b wen=%0b wen_t1=%0b, required 1 0 0 0", f, ar, aw, w1);
    end
  endtask

  task automatic test_rst_rmw();
    logic [31:0] rd, aa;
    int          rc;
    bit          f, ar, aw, w1;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h55;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_w_enable !== 1'b0) begin
      failures++;
      $display("FAIL rst_rmw_wen: mem_w_enable=%0b, required 0", mem_w_enable);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    xact(1'b0, 3'b010, 32'h00, 32'h0, rd, rc, f, ar, aw, aa, w1);
    checks++;
    if (rc !== 2 || rd !== 32'h0) begin
      failures++;
      $display("FAIL rst_rmw_word: cycle=%0d data=%h, required 2 00000000", rc, rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, aa;
    int          rc;
    bit          f, ar, aw, w1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'(4 * i);
      req_wdata  = 32'hA0 + 32'(i);
      #1;
      checks++;
      if (req_ready !== 1'b1 || mem_w_enable !== 1'b1 || mem_address !== 32'(i) ||
          mem_wr_data !== 32'hA0 + 32'(i)) begin
        failures++;
        $display("FAIL b2b_sw%0d: ready=%0b wen=%0b addr=%0d data=%h, required 1 1 %0d %h",
                 i, req_ready, mem_w_enable, mem_address, mem_wr_data, i, 32'hA0 + 32'(i));
      end
      ref_store(3'b010, 32'(4 * i), 32'hA0 + 32'(i));
      @(posedge clk);
    end
    #1 req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      xact(1'b0, 3'b010, 32'(4 * i), 32'h0, rd, rc, f, ar, aw, aa, w1);
      checks++;
      if (rc !== 2 || rd !== 32'hA0 + 32'(i)) begin
        failures++;
        $display("FAIL b2b_readback%0d: cycle=%0d data=%h, required 2 %h", i, rc, rd, 32'hA0 + 32'(i));
      end
    end
    // Second load accepted in the response cycle of the first.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h04;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h08;
    #1;
    checks++;
    if (resp_valid !== 1'b1 || req_ready !== 1'b1 || resp_rdata !== 32'hA1 || mem_r_enable !== 1'b1) begin
      failures++;
      $display("FAIL ld_rsp_accept: rv=%0b ready=%0b data=%h ren=%0b, required 1 1 000000a1 1",
               resp_valid, req_ready, resp_rdata, mem_r_enable);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'hA2) begin
      failures++;
      $display("FAIL ld_rsp_second: rv=%0b data=%h, required 1 000000a2", resp_valid, resp_rdata);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd, aa;
    int          rc;
    bit          f, ar, aw, w1;
    xact(1'b0, 3'b010, 32'h80, 32'h0, rd, rc, f, ar, aw, aa, w1);
    checks++;
    if (aa !== 32'h0 || rc !== 2 || rd !== 32'hA0) begin
      failures++;
      $display("FAIL wrap: addr=%0d cycle=%0d data=%h, required 0 2 000000a0", aa, rc, rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, aa, addr, wd, exp_d;
    logic [2:0]  f3;
    logic        we;
    int          rc;
    bit          f, ar, aw, w1, exp_f;
    for (int i = 0; i < 80; i++) begin
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = 32'($urandom_range(0, 255));
      wd   = $urandom;
      if (!ref_legal(we, f3) && $urandom_range(0, 3) != 0) f3 = 3'b010;
      exp_f = !ref_legal(we, f3) || ref_trap(f3, addr);
      exp_d = (!exp_f && !we) ? ref_load(f3, addr) : 32'h0;
      xact(we, f3, addr, wd, rd, rc, f, ar, aw, aa, w1);
      if (!exp_f && we) ref_store(f3, addr, wd);
      checks++;
      if (exp_f) begin
        if (f !== 1'b1 || rc !== 0 || ar !== 1'b0 || aw !== 1'b0) begin
          failures++;
          $display("FAIL rand%0d_fault: we=%0b f3=%0d addr=%h fault=%0b resp=%0d ren=%0b wen=%0b, required 1 0 0 0",
                   i, we, f3, addr, f, rc, ar, aw);
        end
      end else if (!we) begin
        if (f !== 1'b0 || rc !== 2 || rd !== exp_d) begin
          failures++;
          $display("FAIL rand%0d_load: f3=%0d addr=%h fault=%0b cycle=%0d data=%h, required 0 2 %h",
                   i, f3, addr, f, rc, rd, exp_d);
        end
      end else begin
        if (f !== 1'b0 || rc !== 0) begin
          failures++;
          $display("FAIL rand%0d_store: f3=%0d addr=%h fault=%0b resp=%0d, required 0 0", i, f3, addr, f, rc);
        end
      end
    end
    // Final sweep compares every word against the reference.
    for (int i = 0; i < 32; i++) begin
      xact(1'b0, 3'b010, 32'(4 * i), 32'h0, rd, rc, f, ar, aw, aa, w1);
      checks++;
      if (rc !== 2 || rd !== ref_mem[i]) begin
        failures++;
        $display("FAIL sweep_word%0d: cycle=%0d data=%h, required 2 %h", i, rc, rd, ref_mem[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      dmem[i]    = 32'(i);
      ref_mem[i] = 32'(i);
    end
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    test_reset();
    test_lw_basic();
    test_subword();
    test_misalign();
    test_invalid_f3();
    test_rst_rmw();
    test_back_to_back();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Load/store unit for the MEM stage of the RV32I pipeline. It sits directly upstream of the word-addressed data memory. It converts byte-addressed RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses on the memory's registered read port. Sub-word stores are done as read-modify-write, and load results are returned extracted and sign- or zero-extended.

## Interface
- `DMEM_WORDS`, 32: data memory depth in words; must be a power of two.
- `clk  in  1`: clock; all state updates on the rising edge.
- `rst  in  1`: synchronous reset, active-high.
- `req_valid  in  1`: request present.
- `req_ready  out  1`: request accepted this cycle when `req_valid & req_ready`.
- `req_we  in  1`: 1 = store, 0 = load.
- `req_funct3  in  3`: RV32I funct3 (access size and sign).
- `req_addr  in  32`: byte address.
- `req_wdata  in  32`: store data, right-aligned.
- `resp_valid  out  1`: one-cycle pulse; `resp_rdata` valid.
- `resp_rdata  out  32`: extended load result.
- `req_fault  out  1`: one-cycle pulse; request rejected.
- `mem_r_enable  out  1`: memory read enable.
- `mem_w_enable  out  1`: memory write enable.
- `mem_address  out  32`: word index, zero-extended.
- `mem_wr_data  out  32`: memory write data.
- `mem_re_data  in  32`: registered read data; valid the cycle after `mem_r_enable`.

## Operation
- **Address mapping**
  - Word index = `req_addr[31:2]` mod `DMEM_WORDS`, so the index wraps.
  - Byte lane = `req_addr[1:0]`.
- **States:** IDLE, LD_DATA, LD_RSP, RMW_MERGE.
- **IDLE**
  - `req_ready` = 1.
  - Memory outputs are driven combinationally from the `req_*` inputs when a request is accepted.
  - At the accept edge, the request is latched.
- **Load accepted** (funct3 000/001/010/100/101)
  - Accept cycle: `mem_r_enable` = 1. Next state LD_DATA.
  - LD_DATA: `req_ready` = 0. Extract the lane from `mem_re_data` and register it into `resp_rdata`. Next state LD_RSP.
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
- **LD_RSP**
  - `resp_valid` = 1 and `req_ready` = 1.
  - A new request can be accepted in this cycle, with the same rules as IDLE.
  - Next state: the accepted request's state, otherwise IDLE.
- **SW accepted**
  - `mem_w_enable` = 1 with `mem_wr_data` = `req_wdata` in the accept cycle.
  - Stay in IDLE; stores run at 1 per cycle. No response.
- **SB/SH accepted**
  - Accept cycle: `mem_r_enable` = 1. Next state RMW_MERGE.
  - RMW_MERGE: `req_ready` = 0; `mem_w_enable` = 1.
  - `mem_wr_data` = `mem_re_data` with the addressed byte or halfword replaced by `req_wdata[7:0]` or `req_wdata[15:0]`. The address is the same word.
  - Next state IDLE.
- **Faults**
  - Invalid funct3 for the direction (load 011/110/111; store ≥ 011): no memory enable, `req_fault` pulses the next cycle, stay in IDLE.
  - For misalignment, see Configuration.
- `mem_r_enable` and `mem_w_enable` are never both 1 in the same cycle.
- Both memory enables are forced to 0 while `rst` = 1.

## Timing
- **Reset values:** state IDLE; `resp_valid` 0; `resp_rdata` 0; `req_fault` 0.
  - `req_ready` 0 while `rst` = 1.
  - Memory enables 0 while `rst` = 1.
- **Load latency:** accepted at cycle T, `resp_valid` at T+2. Throughput is 1 load per 2 cycles.
- **Sub-word store occupancy:** 2 cycles; the write happens at T+1.
- **Held requests:** while `req_ready` = 0, the upstream holds `req_*`. Nothing is sampled.
- **Reset during RMW_MERGE:** no write occurs and the memory word is unchanged.
- **Reset during LD_DATA:** no response is produced.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned halfword (`addr[0]`) or word (`addr[1:0]` ≠ 0) accesses are rejected.
  - No memory enable; `req_fault` pulses at T+1.
- Undefined:
  - Low address bits are masked to natural alignment (halfword `addr[0]`=0; word `addr[1:0]`=0) and the access proceeds.
  - `req_fault` is only raised for invalid funct3.

## Structure
- **`lsu_pkg`:** funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) and the state enum.
- **`lsu_byte_lane`:** combinational sub-module, instantiated once. It provides load extract/extend and store merge, given lane, funct3 and data.

## Test plan
Memory is preloaded with word i = i.
- LW 0x14 at T → `mem_r_enable` at T, `mem_address` 5; `resp_valid` at T+2 with 0x00000005.
- SB 0x80 @0x09, then LW 0x08 → 0x00008002.
- Then LB 0x09 → 0xFFFFFF80; LBU 0x09 → 0x00000080.
- SH 0xBEEF @0x0E → word 3 = 0xBEEF0003; LH 0x0E → 0xFFFFBEEF; LHU 0x0E → 0x0000BEEF.
- LW 0x06:
  - With macro → `req_fault` at T+1, no memory enable, no `resp_valid`.
  - Without → response 0x00000001.
- SB @0x00, with `rst` asserted in the RMW_MERGE cycle → `mem_w_enable` stays 0; word 0 reads back 0x00000000 after reset.
- Four back-to-back SWs to 0x00..0x0C (data 0xA0..0xA3) → `req_ready` high throughout; read-back returns 0xA0..0xA3.
- LW @0x80 → wraps to word 0.
